// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared constants for the ALU command sequencer: datapath widths,
// ALU select codes, extended command codes and FSM state encoding.
package alu_cmd_sequencer_pkg;

  localparam int DW  = 4;  // accumulator / operand width
  localparam int SW  = 3;  // ALU select width
  localparam int OPW = 4;  // command opcode width

  // ALU select codes (cmd_op = {1'b0, OP_x})
  localparam logic [SW-1:0] OP_ADD = 3'b000;
  localparam logic [SW-1:0] OP_SUB = 3'b001;
  localparam logic [SW-1:0] OP_AND = 3'b010;
  localparam logic [SW-1:0] OP_OR  = 3'b011;
  localparam logic [SW-1:0] OP_XOR = 3'b100;
  localparam logic [SW-1:0] OP_NOT = 3'b101;
  localparam logic [SW-1:0] OP_SHL = 3'b110;
  localparam logic [SW-1:0] OP_SHR = 3'b111;

  // Sequencer-only commands; 1011..1111 are illegal
  localparam logic [OPW-1:0] CMD_LOAD = 4'b1000;
  localparam logic [OPW-1:0] CMD_MUL  = 4'b1001;
  localparam logic [OPW-1:0] CMD_CLR  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic is_zero(input logic [DW-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the 4-bit combinational ALU. Holds the
// accumulator, drives the ALU for single-cycle ops, runs a 4-step
// shift-and-add multiply through the ALU adder, and returns one response
// per command over a valid/ready handshake.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// EXEC  | one-cycle ALU/LOAD/CLR/illegal update of acc and flags
// MUL   | four shift-and-add iterations through the ALU adder
// RESP  | first cycle publishes rsp_valid, then holds until rsp_ready
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [OPW-1:0] cmd_op,
  input  logic [DW-1:0]  cmd_data,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [SW-1:0]  alu_s,
  input  logic [DW-1:0]  alu_y,
  input  logic           alu_cout,
  input  logic           alu_zero,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_acc,
  output logic           rsp_cout,
  output logic           rsp_zero,
  output logic           rsp_err
);

  state_t          state_q;
  logic [OPW-1:0]  op_q;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   acc_q;
  logic [DW-1:0]   partial_q;
  logic [DW-1:0]   mcand_q;
  logic            lost_q;   // a set bit has been shifted out of mcand
  logic            ovf_q;    // product is known to exceed 4 bits
  logic [1:0]      iter_q;
  logic            cmd_ready_q;
  logic            rsp_valid_q;
  logic            rsp_cout_q;
  logic            rsp_zero_q;
  logic            rsp_err_q;

  logic [DW-1:0]   exec_acc_d;
  logic            exec_cout_d;
  logic            exec_zero_d;
  logic            exec_err_d;

  logic            mul_take;
  logic [DW-1:0]   mul_partial_d;
  logic            mul_ovf_d;
  logic [DW-1:0]   mcand_d;
  logic            lost_d;

  // ALU operand steering: real work only in EXEC (ALU ops) and MUL
  always_comb begin
    alu_a = acc_q;
    alu_b = '0;
    alu_s = OP_ADD;
    if (state_q == ST_EXEC && !op_q[3]) begin
      alu_b = data_q;
      alu_s = op_q[SW-1:0];
    end else if (state_q == ST_MUL) begin
      alu_a = partial_q;
      alu_b = mcand_q;
      alu_s = OP_ADD;
    end
  end

  // Single-cycle command result: ALU capture, LOAD, CLR or illegal
  always_comb begin
    exec_acc_d  = acc_q;
    exec_cout_d = 1'b0;
    exec_zero_d = is_zero(acc_q);
    exec_err_d  = 1'b0;
    if (!op_q[3]) begin
      exec_acc_d  = alu_y;
      exec_cout_d = alu_cout;
      exec_zero_d = alu_zero;
    end else begin
      case (op_q)
        CMD_LOAD: begin
          exec_acc_d  = data_q;
          exec_zero_d = is_zero(data_q);
        end
        CMD_CLR: begin
          exec_acc_d  = '0;
          exec_zero_d = 1'b1;
        end
        default: exec_err_d = 1'b1;
      endcase
    end
  end

  // One shift-and-add step; overflow is flagged when an accumulated term
  // either carries out of the adder or had already lost bits off the top
  always_comb begin
    mul_take      = data_q[iter_q];
    mul_partial_d = mul_take ? alu_y : partial_q;
    mul_ovf_d     = ovf_q | (mul_take & (alu_cout | lost_q));
    mcand_d       = {mcand_q[DW-2:0], 1'b0};
    lost_d        = lost_q | mcand_q[DW-1];
  end

  // Sequencer FSM with registered handshake and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      data_q      <= '0;
      acc_q       <= '0;
      partial_q   <= '0;
      mcand_q     <= '0;
      lost_q      <= 1'b0;
      ovf_q       <= 1'b0;
      iter_q      <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_cout_q  <= 1'b0;
      rsp_zero_q  <= 1'b1;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_op;
            data_q      <= cmd_data;
            cmd_ready_q <= 1'b0;
            if (cmd_op == CMD_MUL) begin
              partial_q <= '0;
              mcand_q   <= acc_q;
              lost_q    <= 1'b0;
              ovf_q     <= 1'b0;
              iter_q    <= '0;
              state_q   <= ST_MUL;
            end else begin
              state_q   <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          acc_q      <= exec_acc_d;
          rsp_cout_q <= exec_cout_d;
          rsp_zero_q <= exec_zero_d;
          rsp_err_q  <= exec_err_d;
          state_q    <= ST_RESP;
        end
        ST_MUL: begin
          partial_q <= mul_partial_d;
          mcand_q   <= mcand_d;
          lost_q    <= lost_d;
          ovf_q     <= mul_ovf_d;
          iter_q    <= iter_q + 2'd1;
          if (iter_q == 2'd3) begin
            acc_q      <= mul_partial_d;
            rsp_cout_q <= mul_ovf_d;
            rsp_zero_q <= is_zero(mul_partial_d);
            rsp_err_q  <= 1'b0;
            state_q    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_acc   = acc_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU beside
// it. The driver pushes hand-computed expectations into a scoreboard; a
// negedge monitor pops and compares whenever a response is presented.
module tb_alu_cmd_sequencer;

  typedef struct {
    logic [3:0] op;
    logic [3:0] data;
    logic [3:0] acc;
    logic       c;
    logic       z;
    logic       e;
    int         lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'h0;
  logic [3:0] cmd_data = 4'h0;
  logic [3:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_s;
  logic       alu_cout, alu_zero;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_acc;
  logic       rsp_cout, rsp_zero, rsp_err;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_v = 1'b0;
  vec_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_acc(rsp_acc), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Behavioural ALU: ADD SUB AND OR XOR NOT SHL SHR
  logic [4:0] alu_t;
  always_comb begin
    alu_t = 5'd0;
    case (alu_s)
      3'd0: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      3'd2: alu_t = {1'b0, alu_a & alu_b};
      3'd3: alu_t = {1'b0, alu_a | alu_b};
      3'd4: alu_t = {1'b0, alu_a ^ alu_b};
      3'd5: alu_t = {1'b0, ~alu_a};
      3'd6: alu_t = {alu_a, 1'b0};
      3'd7: alu_t = {alu_a[0], 1'b0, alu_a[3:1]};
      default: alu_t = 5'd0;
    endcase
  end
  assign alu_y    = alu_t[3:0];
  assign alu_cout = alu_t[4];
  assign alu_zero = (alu_t[3:0] == 4'd0);

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on the rising rsp_valid, fields every presented cycle
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          if (!prev_v) chk("unexpected_rsp", 1, 0);
        end else begin
          if (!prev_v) chk("latency", cyc - acc_cyc - 1, sb[0].lat);
          chk("rsp_acc", int'(rsp_acc), int'(sb[0].acc));
          chk("rsp_cout", int'(rsp_cout), int'(sb[0].c));
          chk("rsp_zero", int'(rsp_zero), int'(sb[0].z));
          chk("rsp_err", int'(rsp_err), int'(sb[0].e));
          if (!rsp_ready) chk("cmd_ready_busy", int'(cmd_ready), 0);
          else void'(sb.pop_front());
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic add(input logic [3:0] op, input logic [3:0] data, input logic [3:0] acc,
                     input logic c, input logic z, input logic e, input int lat);
    vec_t v;
    v.op = op; v.data = data; v.acc = acc; v.c = c; v.z = z; v.e = e; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Called #1 after a rising edge; returns #1 after the acceptance edge
  task automatic send(input vec_t v);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      sb.push_back(v);
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_data  = v.data;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op    = 4'($urandom_range(0, 15));
      cmd_data  = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0 || rsp_valid) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    vec_t v;
    int   n;

    #12;
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_rsp_acc", int'(rsp_acc), 0);
    chk("reset_rsp_zero", int'(rsp_zero), 1);
    chk("reset_rsp_cout", int'(rsp_cout), 0);
    chk("reset_rsp_err", int'(rsp_err), 0);
    chk("reset_alu_b", int'(alu_b), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    //   op     data  acc   c     z     e    lat
    add(4'h8, 4'h9, 4'h9, 1'b0, 1'b0, 1'b0, 2);  // LOAD 9
    add(4'h0, 4'h8, 4'h1, 1'b1, 1'b0, 1'b0, 2);  // ADD 8 -> 17
    add(4'h8, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0, 2);  // LOAD 5
    add(4'h1, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0, 2);  // SUB 5, A>=B
    add(4'h1, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0, 2);  // SUB 1, borrow
    add(4'h8, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 2);  // LOAD 3
    add(4'h9, 4'h5, 4'hF, 1'b0, 1'b0, 1'b0, 5);  // MUL 5 = 15
    add(4'h8, 4'h7, 4'h7, 1'b0, 1'b0, 1'b0, 2);  // LOAD 7
    add(4'h9, 4'h6, 4'hA, 1'b1, 1'b0, 1'b0, 5);  // MUL 6 = 0x2A
    add(4'h8, 4'h6, 4'h6, 1'b0, 1'b0, 1'b0, 2);  // LOAD 6
    add(4'hC, 4'h2, 4'h6, 1'b0, 1'b0, 1'b1, 2);  // illegal 1100
    add(4'h2, 4'h3, 4'h2, 1'b0, 1'b0, 1'b0, 2);  // AND 3 clears err
    add(4'h3, 4'h8, 4'hA, 1'b0, 1'b0, 1'b0, 2);  // OR 8
    add(4'h4, 4'hF, 4'h5, 1'b0, 1'b0, 1'b0, 2);  // XOR F
    add(4'h6, 4'h0, 4'hA, 1'b0, 1'b0, 1'b0, 2);  // SHL
    add(4'h6, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 2);  // SHL, shift-out
    add(4'h7, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0, 2);  // SHR
    add(4'h5, 4'h0, 4'hD, 1'b0, 1'b0, 1'b0, 2);  // NOT
    add(4'hA, 4'h9, 4'h0, 1'b0, 1'b1, 1'b0, 2);  // CLR
    add(4'h9, 4'h7, 4'h0, 1'b0, 1'b1, 1'b0, 5);  // MUL with acc=0
    add(4'h8, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 2);  // LOAD F
    add(4'h9, 4'hF, 4'h1, 1'b1, 1'b0, 1'b0, 5);  // MUL F = 0xE1
    add(4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0, 2);  // ADD 0
    add(4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0, 2);  // SUB 0, no borrow
    add(4'hF, 4'h3, 4'h1, 1'b0, 1'b0, 1'b1, 2);  // illegal 1111
    foreach (vecs[i]) send(vecs[i]);
    drain();

    // Backpressure: response held four cycles while CLR pulses are ignored
    rsp_ready = 1'b0;
    v.op = 4'h8; v.data = 4'h2; v.acc = 4'h2; v.c = 1'b0; v.z = 1'b0; v.e = 1'b0; v.lat = 2;
    send(v);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_rsp_valid", int'(rsp_valid), 1);
    repeat (4) begin
      cmd_valid = 1'b1;
      cmd_op    = 4'hA;
      cmd_data  = 4'h0;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    v.op = 4'h0; v.data = 4'h1; v.acc = 4'h3; v.c = 1'b0; v.z = 1'b0; v.e = 1'b0; v.lat = 2;
    send(v);
    drain();

    // Reset in the middle of a multiply
    v.op = 4'h8; v.data = 4'h3; v.acc = 4'h3; v.c = 1'b0; v.z = 1'b0; v.e = 1'b0; v.lat = 2;
    send(v);
    drain();
    v.op = 4'h9; v.data = 4'h5; v.acc = 4'hF; v.c = 1'b0; v.z = 1'b0; v.e = 1'b0; v.lat = 5;
    send(v);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mulrst_rsp_valid", int'(rsp_valid), 0);
    chk("mulrst_cmd_ready", int'(cmd_ready), 1);
    chk("mulrst_rsp_acc", int'(rsp_acc), 0);
    chk("mulrst_rsp_zero", int'(rsp_zero), 1);
    chk("mulrst_alu_b", int'(alu_b), 0);
    sb.delete();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    v.op = 4'h0; v.data = 4'h4; v.acc = 4'h4; v.c = 1'b0; v.z = 1'b0; v.e = 1'b0; v.lat = 2;
    send(v);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command sequencer directly upstream of the 4-bit combinational ALU (A, B, S → Y, Cout, Zero).
- Accepts operation commands over a valid/ready handshake and holds a 4-bit accumulator.
- Drives the ALU with A = accumulator, B = operand, S = opcode, then captures Y/Cout/Zero back into the accumulator and flags.
- Adds LOAD/CLR/MUL commands; MUL is a 4-cycle iterative shift-and-add that uses the ALU's add.

Parameters:
- none (4-bit datapath, 3-bit ALU select, fixed by the ALU)

Ports:
- clk       in   1  single clock, rising edge
- rst       in   1  asynchronous, active-high reset
- cmd_valid in   1  command present
- cmd_ready out  1  sequencer can accept a command
- cmd_op    in   4  0xxx = ALU op xxx; 1000 LOAD; 1001 MUL; 1010 CLR; 1011–1111 illegal
- cmd_data  in   4  operand (ALU B / load value / multiplier)
- alu_a     out  4  to ALU A
- alu_b     out  4  to ALU B
- alu_s     out  3  to ALU S
- alu_y     in   4  from ALU Y
- alu_cout  in   1  from ALU Cout
- alu_zero  in   1  from ALU Zero
- rsp_valid out  1  response available
- rsp_ready in   1  consumer takes response
- rsp_acc   out  4  accumulator value after the command
- rsp_cout  out  1  carry/borrow/shift-out/overflow flag
- rsp_zero  out  1  1 iff rsp_acc == 0
- rsp_err   out  1  illegal opcode

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE, acc=0, rsp_valid=0, rsp_acc=0, rsp_cout=0, rsp_zero=1, rsp_err=0, cmd_ready=1. Any in-flight command is discarded.
- States:
  - IDLE: cmd_ready=1. On cmd_valid & cmd_ready, register op/data; go to MUL if op=1001, else EXEC.
  - EXEC: one cycle. Update acc and flags; go to RESP.
  - MUL: 4 iterations, i=0..3.
  - RESP: rsp_valid=1, all rsp_* held stable until rsp_ready; then return to IDLE.
- cmd_ready=0 in every state except IDLE. At most one command is outstanding.
- ALU drive in EXEC (0xxx): alu_a=acc, alu_b=data, alu_s=op[2:0]. At the clock edge: acc←alu_y, rsp_cout←alu_cout, rsp_zero←alu_zero, rsp_err=0.
- Outside EXEC/MUL the ALU is driven with alu_a=acc, alu_b=0, alu_s=000; its outputs are ignored.
- LOAD: acc←data. CLR: acc←0. Both give cout=0 and zero=(new acc==0).
- Illegal op: acc unchanged, err=1, cout=0, zero=(acc==0). Takes the same timing as EXEC.
- MUL (acc ← (acc×data) mod 16):
  - Internal partial=0, mcand=acc, mplier=data.
  - Each MUL cycle: alu_s=000, alu_a=partial, alu_b=mcand. If mplier[i]=1, partial←alu_y; otherwise partial is unchanged.
  - Then mcand←mcand<<1 (internal shifter, not the ALU).
  - After i=3: acc←partial, rsp_cout=1 iff the full 8-bit product >15, zero=(acc==0).
- Latency, with acceptance edge = N:
  - ALU/LOAD/CLR/illegal: rsp_valid high after edge N+2.
  - MUL: rsp_valid high after edge N+5.
- The earliest next acceptance is the edge after the rsp handshake (rsp_valid & rsp_ready).
- A command held on cmd_valid while cmd_ready=0 is not consumed. cmd_op/cmd_data may change freely after acceptance.
- SUB (001) borrow: rsp_cout is the ALU carry out of A + (~B+1). It is 1 when A≥B, including B=0.
- Accumulator wraps mod 16 on every arithmetic op; there is no saturation.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD..OP_SHR (000–111) and CMD_LOAD/CMD_MUL/CMD_CLR;
  - state encoding (IDLE, EXEC, MUL, RESP);
  - width constant DW=4.
- No sub-module required. The ALU is instantiated beside this block at the next level up, not inside it.

Test Plan:
- LOAD 9, then ADD 8: rsp_acc=1, rsp_cout=1, rsp_zero=0; rsp_valid asserted exactly 2 cycles after acceptance.
- LOAD 5, SUB 5: rsp_acc=0, rsp_zero=1, rsp_cout=1. Then SUB 1: rsp_acc=F, rsp_cout=0.
- LOAD 3, MUL 5: rsp_acc=F, rsp_cout=0, latency 5. LOAD 7, MUL 6: rsp_acc=A, rsp_cout=1.
- Opcode 1100 with acc=6: rsp_err=1, rsp_acc=6, rsp_cout=0. The next legal command clears err.
- Backpressure: hold rsp_ready=0 for 4 cycles. rsp_* stay stable, cmd_ready stays 0, and cmd_valid pulses are not consumed.
- Assert rst during MUL iteration 2: rsp_valid drops at once, acc=0, cmd_ready=1. A post-reset ADD 4 gives 4.
